mux8_rr_arbiter: RTL and testbench
==================================

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 4, meaning the maximum consecutive cycles one requester may hold the grant (legal range 1..7).
REQ-002 Port list: clk  input  1  rising-edge clock.
REQ-003 Port list: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port list: req  input  8  request lines; req[i] asks for mux input i.
REQ-005 Port list: D  input  8  mux data inputs; D[i] belongs to requester i.
REQ-006 Port list: gnt  output  8  registered one-hot grant, or all-zero when idle.
REQ-007 Port list: S  output  3  registered select driving the 8:1 mux; equals the index of the set gnt bit.
REQ-008 Port list: busy  output  1  registered; 1 while any grant is active.
REQ-009 Port list: P  output  1  shared mux output, D[S] when busy=1, else 0.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT, plus a 3-bit round-robin pointer ptr and a 3-bit hold counter hcnt.
REQ-011 In IDLE, the block SHALL pick the winner as the first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7 mod 8.
REQ-012 Grant latency SHALL be one cycle: req sampled at edge n gives gnt, S and busy valid after edge n.
REQ-013 On every grant issue, the block SHALL set ptr to winner+1 mod 8 and hcnt to 1.
REQ-014 In GRANT, the block SHALL keep the owner and increment hcnt while req[owner]=1 and hcnt<HOLD_MAX.
REQ-015 The block SHALL release the owner on the edge where req[owner]=0 or hcnt=HOLD_MAX.
REQ-016 On release, the block SHALL re-arbitrate on that same edge using the REQ-011 scan with ptr=owner+1, so the owner is lowest priority; there SHALL be no idle bubble when any req is set.
REQ-017 On release, when req is all-zero, the block SHALL go to IDLE: gnt=0, busy=0, and S holds its last value.
REQ-018 When the expired owner is the only requester, the block SHALL grant it again with hcnt=1.
REQ-019 When several requests arrive simultaneously, or a new request arrives during a grant, the arbitration SHALL follow REQ-011 and REQ-016 only, with no preemption.
REQ-020 When HOLD_MAX=1, the grant SHALL rotate every cycle among the active requesters.
REQ-021 P SHALL be combinational from S and D; gnt SHALL be one-hot or zero in every cycle.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL force: state=IDLE, gnt=8'h00, S=3'd0, busy=0, ptr=0, hcnt=0.
REQ-023 Reset SHALL take priority over all requests, including in the middle of a grant; the first grant after reset SHALL use the scan from index 0.
REQ-024 P SHALL read 0 while busy=0, including during reset.

Structure
REQ-025 The shared package SHALL hold the state encoding (IDLE=0, GRANT=1), the requester count constant 8, and the select width 3.
REQ-026 The block SHALL instantiate the existing mux8_1_if sub-module for the P datapath (P, D, S), gated by busy.
REQ-027 The round-robin scan SHALL be a single combinational function inside the block; no other sub-module is required.

Verification
REQ-028 Reset then single request: rst_n=0 for 2 cycles, then req=8'h10 and D=8'h10 -> after 1 edge gnt=8'h10, S=4, busy=1, P=1.
REQ-029 Hold limit: req=8'h05 held with HOLD_MAX=4 -> gnt=8'h01 for 4 cycles, then 8'h04 for 4 cycles, then 8'h01, with no gap.
REQ-030 Early release: owner 2 drops req after 2 cycles while req[6]=1 -> gnt goes 8'h04, 8'h04, 8'h40 on consecutive edges.
REQ-031 Sole requester: req=8'h80 held with HOLD_MAX=4 -> gnt stays 8'h80 continuously, and ptr is 0 after each regrant (wrap-around).
REQ-032 All request: req=8'hFF with HOLD_MAX=1 -> S sequence is 0,1,2,...,7,0; gnt is one-hot every cycle.
REQ-033 Reset mid-grant: rst_n=0 during an owner-5 grant -> next edge gnt=0, busy=0, S=0, P=0; after rst_n=1, req=8'h21 grants index 0 first.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter and its
// output mux.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of one round-robin scan: whether anyone is requesting, and who won.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/mux8_rr_arbiter_mux8_1_if.sv
// 8:1 single-bit data mux with an enable; the output is forced low when
// the enable is off.
module mux8_1_if
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] D,
  input  logic [SEL_W-1:0] S,
  input  logic             en,
  output logic             P
);

  assign P = en & D[S];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter over 8 requesters with a bounded hold time; the
// granted index steers a shared 8:1 data mux.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] D,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] S,
  output logic             busy,
  output logic             P
);

  localparam logic [SEL_W-1:0] HOLD_LIM = SEL_W'(HOLD_MAX);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] hcnt;
  logic [SEL_W-1:0] scan_base;
  logic             hold_ok;
  pick_t            pick;

  // First requester found when scanning base, base+1, ..., base+7 (mod 8).
  // The loop runs from the far end so the nearest hit is the one that sticks.
  function automatic pick_t rr_scan(input logic [N_REQ-1:0] r,
                                    input logic [SEL_W-1:0] base);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = base + SEL_W'(k);
      if (r[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  // On release the owner drops to lowest priority by scanning from owner+1.
  always_comb begin
    hold_ok   = (state == GRANT) && req[S] && (hcnt < HOLD_LIM);
    scan_base = (state == GRANT) ? S + SEL_W'(1) : ptr;
    pick      = rr_scan(req, scan_base);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      S     <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      hcnt  <= '0;
    end else if (hold_ok) begin
      hcnt <= hcnt + SEL_W'(1);
    end else if (pick.found) begin
      state <= GRANT;
      gnt   <= N_REQ'(1) << pick.idx;
      S     <= pick.idx;
      busy  <= 1'b1;
      ptr   <= pick.idx + SEL_W'(1);
      hcnt  <= SEL_W'(1);
    end else begin
      // Nobody left to serve; S keeps the last owner.
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      hcnt  <= '0;
    end
  end

  mux8_1_if u_mux (
    .D  (D),
    .S  (S),
    .en (busy),
    .P  (P)
  );

  assert property (@(posedge clk) $onehot0(gnt));
  assert property (@(posedge clk) busy == (state == GRANT));
  assert property (@(posedge clk) gnt == (busy ? (N_REQ'(1) << S) : '0));

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: two instances (hold limits 4 and 1) driven by
// the same stimulus and checked against a queue-free behavioural model.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] D;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] s_a, s_b;
  logic       busy_a, busy_b, p_a, p_b;

  int vectors     = 0;
  int miscompares = 0;

  int hold_lim [2] = '{4, 1};
  int m_busy   [2];
  int m_own    [2];
  int m_sel    [2];
  int m_cnt    [2];
  int m_ptr    [2];

  logic [25:0] exp_q[$];

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.HOLD_MAX(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .D(D),
    .gnt(gnt_a), .S(s_a), .busy(busy_a), .P(p_a)
  );

  mux8_rr_arbiter #(.HOLD_MAX(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .D(D),
    .gnt(gnt_b), .S(s_b), .busy(busy_b), .P(p_b)
  );

  // Reference model: who owns the grant, for how long, and where the next scan starts.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_busy[m] = 0; m_own[m] = 0; m_sel[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0;
      end else if (m_busy[m] != 0 && req[m_own[m]] && m_cnt[m] < hold_lim[m]) begin
        m_cnt[m] = m_cnt[m] + 1;
      end else begin
        int start;
        int win;
        start = (m_busy[m] != 0) ? (m_own[m] + 1) % 8 : m_ptr[m];
        win = -1;
        for (int i = 0; i < 8; i++)
          if (win < 0 && req[(start + i) % 8]) win = (start + i) % 8;
        if (win >= 0) begin
          m_busy[m] = 1; m_own[m] = win; m_sel[m] = win;
          m_ptr[m] = (win + 1) % 8; m_cnt[m] = 1;
        end else begin
          m_busy[m] = 0;
        end
      end
    end
  endtask

  function automatic logic [12:0] model_out(int m);
    logic [7:0] g;
    logic       b;
    b = (m_busy[m] != 0);
    g = b ? (8'd1 << m_own[m]) : 8'd0;
    return {g, 3'(m_sel[m]), b, b ? D[m_sel[m]] : 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; D = 8'hFF;
    tick(); tick();
    vectors++;
    if ({gnt_a, s_a, busy_a, p_a} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_a got %h want 0", {gnt_a, s_a, busy_a, p_a});
    end
    vectors++;
    if ({gnt_b, s_b, busy_b, p_b} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_b got %h want 0", {gnt_b, s_b, busy_b, p_b});
    end
    vectors++;
    if (dut_a.ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ptr got %0d want 0", dut_a.ptr);
    end
  endtask

  task automatic test_single();
    rst_n = 1'b1; req = 8'h10; D = 8'h10;
    tick();
    vectors++;
    if ({gnt_a, s_a, busy_a, p_a} !== {8'h10, 3'd4, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_a got gnt=%h S=%0d busy=%b P=%b want gnt=10 S=4 busy=1 P=1",
               gnt_a, s_a, busy_a, p_a);
    end
    vectors++;
    if ({gnt_b, s_b, busy_b, p_b} !== {8'h10, 3'd4, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_b got gnt=%h S=%0d busy=%b P=%b want gnt=10 S=4 busy=1 P=1",
               gnt_b, s_b, busy_b, p_b);
    end
    D = 8'hEF;
    #1;
    vectors++;
    if (p_a !== 1'b0) begin
      miscompares++;
      $display("FAIL p_follows_d got %b want 0", p_a);
    end
    req = 8'h00; D = 8'h10;
    tick();
    vectors++;
    if ({gnt_a, s_a, busy_a, p_a} !== {8'h00, 3'd4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_hold_s got gnt=%h S=%0d busy=%b P=%b want gnt=00 S=4 busy=0 P=0",
               gnt_a, s_a, busy_a, p_a);
    end
  endtask

  task automatic test_hold_limit();
    logic [7:0] exp_g;
    req = 8'h05;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_g = (i < 4 || i == 8) ? 8'h01 : 8'h04;
      vectors++;
      if (gnt_a !== exp_g || busy_a !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_limit cyc %0d got gnt=%h busy=%b want gnt=%h busy=1",
                 i, gnt_a, busy_a, exp_g);
      end
      vectors++;
      if ({gnt_b, s_b, busy_b, p_b} !== model_out(1)) begin
        miscompares++;
        $display("FAIL hold_limit_b cyc %0d got %h want %h", i, {gnt_b, s_b, busy_b, p_b}, model_out(1));
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_early_release();
    logic [7:0] exp_g [3];
    exp_g = '{8'h04, 8'h04, 8'h40};
    req = 8'h44;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) req = 8'h40;
      tick();
      vectors++;
      if (gnt_a !== exp_g[i]) begin
        miscompares++;
        $display("FAIL early_release cyc %0d got %h want %h", i, gnt_a, exp_g[i]);
      end
    end
    req = 8'h00;
    tick();
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL early_release_idle got busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_sole();
    req = 8'h80;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (gnt_a !== 8'h80 || busy_a !== 1'b1 || dut_a.ptr !== 3'd0) begin
        miscompares++;
        $display("FAIL sole cyc %0d got gnt=%h busy=%b ptr=%0d want gnt=80 busy=1 ptr=0",
                 i, gnt_a, busy_a, dut_a.ptr);
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_all_req();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 8'hFF; D = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if (s_b !== 3'(i % 8) || gnt_b !== (8'd1 << (i % 8)) || busy_b !== 1'b1) begin
        miscompares++;
        $display("FAIL all_req cyc %0d got S=%0d gnt=%h busy=%b want S=%0d",
                 i, s_b, gnt_b, busy_b, i % 8);
      end
      vectors++;
      if ({gnt_a, s_a, busy_a, p_a} !== model_out(0)) begin
        miscompares++;
        $display("FAIL all_req_a cyc %0d got %h want %h", i, {gnt_a, s_a, busy_a, p_a}, model_out(0));
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 8'h20; D = 8'hFF;
    tick();
    vectors++;
    if (gnt_a !== 8'h20 || s_a !== 3'd5) begin
      miscompares++;
      $display("FAIL mid_setup got gnt=%h S=%0d want gnt=20 S=5", gnt_a, s_a);
    end
    tick();
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({gnt_a, s_a, busy_a, p_a} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_reset got gnt=%h S=%0d busy=%b P=%b want all 0", gnt_a, s_a, busy_a, p_a);
    end
    rst_n = 1'b1; req = 8'h21;
    tick();
    vectors++;
    if (gnt_a !== 8'h01 || s_a !== 3'd0 || gnt_b !== 8'h01) begin
      miscompares++;
      $display("FAIL after_reset got gnt_a=%h S=%0d gnt_b=%h want 01 0 01", gnt_a, s_a, gnt_b);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [25:0] exp;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = 8'h00;
          1:       req = 8'd1 << $urandom_range(0, 7);
          default: req = 8'($urandom);
        endcase
      end
      D = 8'($urandom);
      tick();
      exp_q.push_back({model_out(0), model_out(1)});
      exp = exp_q.pop_front();
      vectors++;
      if ({gnt_a, s_a, busy_a, p_a, gnt_b, s_b, busy_b, p_b} !== exp) begin
        miscompares++;
        $display("FAIL random cyc %0d req=%h got %h want %h", n, req,
                 {gnt_a, s_a, busy_a, p_a, gnt_b, s_b, busy_b, p_b}, exp);
      end
      vectors++;
      if (!$onehot0(gnt_a) || !$onehot0(gnt_b)) begin
        miscompares++;
        $display("FAIL onehot cyc %0d got gnt_a=%h gnt_b=%h want one-hot or zero", n, gnt_a, gnt_b);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; D = 8'h00;
    test_reset();
    test_single();
    test_hold_limit();
    test_early_release();
    test_sole();
    test_all_req();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
